// File: rtl/ai_i2s_wb_pkg.sv
// Shared types, register offsets and burst address helper for the I2S Wishbone slave.
package ai_i2s_wb_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_CONST   = 3'b001,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_e;

  localparam int OFF_CTRL   = 0;
  localparam int OFF_STATUS = 1;
  localparam int OFF_TX     = 2;
  localparam int OFF_RX     = 3;

  // Wrapping keeps the upper bits of the block and lets only the masked bits roll over.
  function automatic logic [31:0] next_beat_addr(input logic [31:0] addr,
                                                 input logic [2:0]  cti,
                                                 input logic [1:0]  bte,
                                                 input logic [31:0] bytes);
    logic [31:0] inc;
    logic [31:0] mask;
    inc = addr + bytes;
    case (bte)
      BTE_WRAP4:  mask = (bytes << 2) - 32'd1;
      BTE_WRAP8:  mask = (bytes << 3) - 32'd1;
      BTE_WRAP16: mask = (bytes << 4) - 32'd1;
      default:    mask = '1;
    endcase
    if (cti == CTI_INCR) return (addr & ~mask) | (inc & mask);
    else                 return addr;
  endfunction

endpackage

// File: rtl/ai_i2s_wb_burst_slave_addr_gen.sv
// Registered beat address: loaded at the first beat, stepped at each acknowledged burst edge.
module ai_i2s_wb_addr_gen
  import ai_i2s_wb_pkg::*;
#(
  parameter int AW    = 8,
  parameter int BYTES = 4
) (
  input  logic          wb_clk_i,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic          advance,
  input  logic [2:0]    cti,
  input  logic [1:0]    bte,
  output logic [AW-1:0] beat_addr,
  output logic [AW-1:0] next_addr
);

  logic [AW-1:0] beat_addr_p1;

  // Truncation to AW gives the modulo-2^AW behaviour of linear bursts.
  assign next_addr = AW'(next_beat_addr(32'(beat_addr_p1), cti, bte, 32'(BYTES)));
  assign beat_addr = beat_addr_p1;

  always_ff @(posedge wb_clk_i) begin
    if (load)         beat_addr_p1 <= load_addr;
    else if (advance) beat_addr_p1 <= next_addr;
  end

endmodule

// File: rtl/ai_i2s_wb_burst_slave.sv
// Wishbone B3 burst slave for per-channel I2S CTRL/STATUS/TX/RX registers.
// Define AI_I2S_WB_ERR_EN to answer illegal beats with wb_err_o instead of wb_ack_o.
module ai_i2s_wb_burst_slave
  import ai_i2s_wb_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 8,
  parameter int NUM_CH      = 4,
  parameter int REGS_PER_CH = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [AW-1:0]        wb_adr_i,
  input  logic [DW-1:0]        wb_dat_i,
  input  logic [DW/8-1:0]      wb_sel_i,
  input  logic                 wb_we_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic [2:0]           wb_cti_i,
  input  logic [1:0]           wb_bte_i,
  output logic [DW-1:0]        wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic [NUM_CH*DW-1:0] ch_ctrl_o,
  input  logic [NUM_CH*DW-1:0] ch_status_i,
  output logic [DW-1:0]        ch_tx_dat_o,
  output logic [NUM_CH-1:0]    ch_tx_ack_o,
  input  logic [NUM_CH*DW-1:0] ch_rx_dat_i,
  output logic [NUM_CH-1:0]    ch_rx_ack_o
);

  localparam int BYTES = DW / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int OFF_W = $clog2(REGS_PER_CH);
  localparam int CH_W  = AW - LSB - OFF_W;
  localparam int CH_N  = 2 ** CH_W;

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [OFF_W-1:0] off;
    logic             legal;
  } beat_t;

  function automatic beat_t decode(input logic [AW-1:0] a, input logic we);
    beat_t b;
    b.off   = a[LSB +: OFF_W];
    b.ch    = a[LSB+OFF_W +: CH_W];
    b.legal = (int'(b.ch) < NUM_CH) &&
              ((int'(b.off) == OFF_CTRL) ||
               (int'(b.off) == OFF_STATUS && !we) ||
               (int'(b.off) == OFF_TX     &&  we) ||
               (int'(b.off) == OFF_RX     && !we));
    return b;
  endfunction

  function automatic logic [DW-1:0] merge_sel(input logic [DW-1:0]   old_w,
                                              input logic [DW-1:0]   new_w,
                                              input logic [DW/8-1:0] sel);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < DW/8; i++)
      if (sel[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  state_e        state_q, state_d;
  logic          load, advance, issue, commit, complete, last_beat;
  logic          ack_d, err_d;
  logic          ack_p1, err_p1;
  logic [DW-1:0] dat_p1, rd_word;
  logic [AW-1:0] beat_addr, next_addr, issue_addr;
  beat_t         issue_b, beat_b;
  logic          wr_ok, rd_ok;

  logic [DW-1:0]     ctrl_q   [NUM_CH];
  logic [DW-1:0]     ctrl_a   [CH_N];
  logic [DW-1:0]     status_a [CH_N];
  logic [DW-1:0]     rx_a     [CH_N];
  logic [DW-1:0]     tx_dat_q;
  logic [NUM_CH-1:0] tx_ack_q, rx_ack_q;

  for (genvar c = 0; c < CH_N; c++) begin : g_ch
    if (c < NUM_CH) begin : g_map
      assign ctrl_a[c]               = ctrl_q[c];
      assign status_a[c]             = ch_status_i[c*DW +: DW];
      assign rx_a[c]                 = ch_rx_dat_i[c*DW +: DW];
      assign ch_ctrl_o[c*DW +: DW]   = ctrl_q[c];
    end else begin : g_unmap
      assign ctrl_a[c]   = '0;
      assign status_a[c] = '0;
      assign rx_a[c]     = '0;
    end
  end

  ai_i2s_wb_addr_gen #(.AW(AW), .BYTES(BYTES)) u_addr_gen (
    .wb_clk_i  (wb_clk_i),
    .load      (load),
    .load_addr (wb_adr_i),
    .advance   (advance),
    .cti       (wb_cti_i),
    .bte       (wb_bte_i),
    .beat_addr (beat_addr),
    .next_addr (next_addr)
  );

  // A pending beat only completes while the master is strobing it.
  assign complete   = (ack_p1 | err_p1) & wb_cyc_i & wb_stb_i;
  assign last_beat  = !((wb_cti_i == CTI_CONST) || (wb_cti_i == CTI_INCR));
  assign issue_addr = (state_q == ST_IDLE) ? wb_adr_i : next_addr;
  assign issue_b    = decode(issue_addr, wb_we_i);
  assign beat_b     = decode(beat_addr, wb_we_i);
  assign wr_ok      = commit &  wb_we_i & beat_b.legal;
  assign rd_ok      = commit & !wb_we_i & beat_b.legal;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    issue   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          load    = 1'b1;
          issue   = 1'b1;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (complete) begin
          commit = 1'b1;
          if (last_beat) begin
            state_d = ST_IDLE;
          end else begin
            advance = 1'b1;
            issue   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    if (issue_b.legal && !wb_we_i) begin
      case (int'(issue_b.off))
        OFF_CTRL:   rd_word = ctrl_a[issue_b.ch];
        OFF_STATUS: rd_word = status_a[issue_b.ch];
        OFF_RX:     rd_word = rx_a[issue_b.ch];
        default:    rd_word = '0;
      endcase
    end
`ifdef AI_I2S_WB_ERR_EN
    ack_d =  issue_b.legal;
    err_d = !issue_b.legal;
`else
    ack_d = 1'b1;
    err_d = 1'b0;
`endif
  end

  // Stage p1: registered acknowledge and read data for the issued beat.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_p1 <= 1'b0;
      err_p1 <= 1'b0;
      dat_p1 <= '0;
    end else if (issue) begin
      ack_p1 <= ack_d;
      err_p1 <= err_d;
      dat_p1 <= rd_word;
    end else if (state_d == ST_IDLE) begin
      ack_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end
  end

  // Side effects commit on the edge that ends the acknowledged beat.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int c = 0; c < NUM_CH; c++) ctrl_q[c] <= '0;
      tx_dat_q <= '0;
      tx_ack_q <= '0;
      rx_ack_q <= '0;
    end else begin
      tx_ack_q <= '0;
      rx_ack_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_ok && int'(beat_b.off) == OFF_CTRL && int'(beat_b.ch) == c)
          ctrl_q[c] <= merge_sel(ctrl_q[c], wb_dat_i, wb_sel_i);
        if (wr_ok && int'(beat_b.off) == OFF_TX && int'(beat_b.ch) == c)
          tx_ack_q[c] <= 1'b1;
        if (rd_ok && int'(beat_b.off) == OFF_RX && int'(beat_b.ch) == c)
          rx_ack_q[c] <= 1'b1;
      end
      if (wr_ok && int'(beat_b.off) == OFF_TX)
        tx_dat_q <= merge_sel(tx_dat_q, wb_dat_i, wb_sel_i);
    end
  end

  assign wb_ack_o    = ack_p1 & wb_cyc_i & wb_stb_i;
  assign wb_err_o    = err_p1 & wb_cyc_i & wb_stb_i;
  assign wb_dat_o    = dat_p1;
  assign ch_tx_dat_o = tx_dat_q;
  assign ch_tx_ack_o = tx_ack_q;
  assign ch_rx_ack_o = rx_ack_q;

endmodule

// File: tb/tb_ai_i2s_wb_burst_slave.sv
// Directed bench for ai_i2s_wb_burst_slave: classic, byte-lane, burst, wait-state and reset cases.
module tb_ai_i2s_wb_burst_slave;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NC = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_i;
  logic [3:0]      sel;
  logic            we, cyc, stb;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic [DW-1:0]   dat_o;
  logic            ack, err;
  logic [NC*DW-1:0] ctrl, status, rx_dat;
  logic [DW-1:0]   tx_dat;
  logic [NC-1:0]   tx_ack, rx_ack;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] r_dat;
  logic        r_ack, r_err;

  always #5 clk = ~clk;

  ai_i2s_wb_burst_slave #(.DW(DW), .AW(AW), .NUM_CH(NC), .REGS_PER_CH(4)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wb_adr_i    (adr),
    .wb_dat_i    (dat_i),
    .wb_sel_i    (sel),
    .wb_we_i     (we),
    .wb_cyc_i    (cyc),
    .wb_stb_i    (stb),
    .wb_cti_i    (cti),
    .wb_bte_i    (bte),
    .wb_dat_o    (dat_o),
    .wb_ack_o    (ack),
    .wb_err_o    (err),
    .ch_ctrl_o   (ctrl),
    .ch_status_i (status),
    .ch_tx_dat_o (tx_dat),
    .ch_tx_ack_o (tx_ack),
    .ch_rx_dat_i (rx_dat),
    .ch_rx_ack_o (rx_ack)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One classic transfer; returns what was seen in the acknowledge cycle.
  task automatic classic(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic w, output logic [31:0] rd, output logic ak, output logic er);
    adr = a; dat_i = d; sel = s; we = w; cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    tick();
    rd = dat_o; ak = ack; er = err;
    tick();
    chk("classic_gap", {126'd0, ack, err}, 128'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < NC; c++) begin
      status[c*DW +: DW] = 32'h5700_0000 + c;
      rx_dat[c*DW +: DW] = 32'hCAFE_00C0 + c;
    end
    rst = 1'b1; adr = '0; dat_i = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    cti = 3'b000; bte = 2'b00;
    tick(); tick();
    chk("rst_ack", {126'd0, ack, err}, 128'd0);
    chk("rst_ctrl", ctrl, 128'd0);
    chk("rst_dat", dat_o, 128'd0);
    chk("rst_pulses", {tx_ack, rx_ack}, 128'd0);
    chk("rst_txdat", tx_dat, 128'd0);
    rst = 1'b0;
    tick();

    // Classic full-word write to ch1 CTRL
    classic(8'h10, 32'hA5A5_1234, 4'hF, 1'b1, r_dat, r_ack, r_err);
    chk("wr_ctrl_ack", r_ack, 128'd1);
    chk("wr_ctrl_val", ctrl[63:32], 128'hA5A5_1234);

    // Byte-lane write
    classic(8'h10, 32'h0000_FF00, 4'b0010, 1'b1, r_dat, r_ack, r_err);
    chk("byte_wr_val", ctrl[63:32], 128'hA5A5_FF34);
    chk("byte_wr_ch0", ctrl[31:0], 128'd0);

    // Preload ch0 CTRL for the burst
    classic(8'h00, 32'h1111_2222, 4'hF, 1'b1, r_dat, r_ack, r_err);
    chk("wr_ctrl0", ctrl[31:0], 128'h1111_2222);

    // Wrap4 read burst from 0x08: TX(0), RX0, CTRL0, STATUS0
    adr = 8'h08; we = 1'b0; sel = 4'hF; cti = 3'b010; bte = 2'b01; cyc = 1'b1; stb = 1'b1;
    tick();
    chk("wr4_b0_ack", ack, 128'd1);
    chk("wr4_b0_dat", dat_o, 128'd0);
    adr = 8'h0C;
    tick();
    chk("wr4_b1_ack", ack, 128'd1);
    chk("wr4_b1_dat", dat_o, 128'hCAFE_00C0);
    chk("wr4_b1_rxack", rx_ack, 128'd0);
    adr = 8'h00;
    tick();
    chk("wr4_b2_ack", ack, 128'd1);
    chk("wr4_b2_dat", dat_o, 128'h1111_2222);
    chk("wr4_b2_rxack", rx_ack, 128'h1);
    adr = 8'h04;
    tick();
    chk("wr4_b3_ack", ack, 128'd1);
    chk("wr4_b3_dat", dat_o, 128'h5700_0000);
    chk("wr4_b3_rxack", rx_ack, 128'd0);
    cti = 3'b111;
    tick();
    chk("wr4_end_ack", ack, 128'd0);
    cyc = 1'b0; stb = 1'b0; cti = 3'b000; bte = 2'b00;
    tick();

    // Linear burst with a 2-cycle wait after beat 2: RX0, CTRL1, STATUS1
    adr = 8'h0C; we = 1'b0; cti = 3'b010; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    tick();
    chk("ws_b1_dat", dat_o, 128'hCAFE_00C0);
    tick();
    chk("ws_b2_ack", ack, 128'd1);
    chk("ws_b2_dat", dat_o, 128'hA5A5_FF34);
    tick();
    stb = 1'b0;
    #1;
    chk("ws_wait1_ack", ack, 128'd0);
    tick();
    chk("ws_wait2_ack", ack, 128'd0);
    tick();
    stb = 1'b1; cti = 3'b111;
    #1;
    chk("ws_b3_ack", ack, 128'd1);
    chk("ws_b3_dat", dat_o, 128'h5700_0001);
    tick();
    chk("ws_end_ack", ack, 128'd0);
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    tick();

    // TX write to ch3
    classic(8'h38, 32'hDEAD_BEEF, 4'hF, 1'b1, r_dat, r_ack, r_err);
    chk("tx_ack_pulse", tx_ack, 128'b1000);
    chk("tx_dat", tx_dat, 128'hDEAD_BEEF);
    tick();
    chk("tx_ack_clear", tx_ack, 128'd0);

    // Unmapped channel 8
    classic(8'h80, 32'h0, 4'hF, 1'b0, r_dat, r_ack, r_err);
`ifdef AI_I2S_WB_ERR_EN
    chk("unmap_ack", {r_ack, r_err}, 128'b01);
`else
    chk("unmap_ack", {r_ack, r_err}, 128'b10);
`endif
    chk("unmap_dat", r_dat, 128'd0);

    // Reset in the middle of a burst
    adr = 8'h00; we = 1'b0; cti = 3'b010; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    tick();
    chk("rb_b0_ack", ack, 128'd1);
    rst = 1'b1;
    tick();
    chk("rb_ack_drop", ack, 128'd0);
    chk("rb_ctrl_zero", ctrl, 128'd0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    tick();
    classic(8'h14, 32'h0, 4'hF, 1'b0, r_dat, r_ack, r_err);
    chk("post_rst_ack", r_ack, 128'd1);
    chk("post_rst_dat", r_dat, 128'h5700_0001);
    classic(8'h10, 32'h0, 4'hF, 1'b0, r_dat, r_ack, r_err);
    chk("post_rst_ctrl", r_dat, 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
